keypad_emulator: RTL and testbench
==================================

KEYPAD_EMULATOR -- requirements
Module: keypad_emulator

Interface
REQ-001 Parameter BOUNCE_LEN, default 8: cycles of contact bounce emulated at press start.
REQ-002 Parameter GAP_LEN, default 16: minimum released cycles after a key release before the next command is accepted.
REQ-003 clock  input  1  the only clock; all state updates on its rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 cmd_valid  input  1  key-press command offered.
REQ-006 cmd_ready  output  1  high when a command can be accepted.
REQ-007 cmd_key  input  4  key code 0x0-0xF to press.
REQ-008 cmd_hold  input  16  number of counted row visits to hold the key; 0 is treated as 1.
REQ-009 keypadRow  input  4  scanner row drive, active-low one-hot.
REQ-010 keypadCol  output  4  emulated column return, active-low; 4'b1111 means no key.
REQ-011 busy  output  1  high while a command is in progress.
REQ-012 done  output  1  one-cycle pulse when a command completes.

Function
REQ-013 The block SHALL map the key to a target (row, col) pattern.
- Row 1110: keys 7,4,1,0.
- Row 1101: keys 8,5,2,A.
- Row 1011: keys 9,6,3,B.
- Row 0111: keys C,D,E,F.
- Within each row, the four keys map to col 1110, 1101, 1011, 0111 respectively.
REQ-014 The block SHALL use the states IDLE, BOUNCE, HOLD and GAP.
REQ-015 cmd_ready SHALL equal (state==IDLE).
- A transfer occurs when cmd_valid && cmd_ready.
- On transfer, the block SHALL latch key and hold, then enter BOUNCE.
REQ-016 While not IDLE, cmd_valid SHALL be ignored and the latched command SHALL stay stable.
REQ-017 busy SHALL equal (state!=IDLE).
REQ-018 keypadCol SHALL be registered: 1-cycle latency from keypadRow.
REQ-019 In HOLD: keypadCol = target col when the sampled keypadRow equals the target row; otherwise 4'b1111.
REQ-020 In BOUNCE: behaves as HOLD on even bounce-counter values and drives 4'b1111 on odd values.
- The bounce counter runs 0..BOUNCE_LEN-1.
- BOUNCE SHALL then go to HOLD.
REQ-021 In IDLE and GAP, keypadCol SHALL be 4'b1111.
REQ-022 A hit is a cycle in which keypadRow equals the target row and the previously sampled keypadRow did not.
- Hits SHALL be counted only in HOLD.
- The hit counter is 16 bits and saturates at 0xFFFF.
REQ-023 HOLD SHALL exit to GAP on the first cycle where hit count >= max(hold,1) and keypadRow != target row, so a release never truncates a row visit.
REQ-024 A keypadRow value that is not active-low one-hot (e.g. 1111, 0000, 1100) SHALL produce 4'b1111 and never count as a hit.
REQ-025 GAP SHALL last exactly GAP_LEN cycles, then enter IDLE.
- done SHALL pulse high for the single cycle in which GAP transitions to IDLE.
REQ-026 A hold of 1 with a row already at target at HOLD entry SHALL NOT count that visit (no edge); only a fresh visit counts.

Reset
REQ-027 reset asserted SHALL immediately force:
- state IDLE;
- keypadCol 4'b1111;
- cmd_ready 1, busy 0, done 0;
- all counters and latched command cleared;
- previous-row register set to 4'b1111.
REQ-028 Reset mid-command SHALL abandon the command with no done pulse.
- The first command can be accepted on the first clock edge after reset deasserts.

Structure
REQ-029 The shared package keypad_pkg SHALL hold:
- the state encoding;
- row pattern constants ROW0..ROW3 = 1110,1101,1011,0111;
- col pattern constants COL0..COL3 = 1110,1101,1011,0111;
- the no-key constant 4'b1111.
REQ-030 The key-code to (row, col) lookup SHALL be a combinational sub-module keypad_key_map, reused by the scanner side.

Verification
REQ-031 Press key 0x5, hold 2, BOUNCE_LEN 0, scanner cycling 1110->1101->1011->0111 every 100 cycles.
- Required: keypadCol=1101 one cycle after each 1101 row entry, for 2 visits, else 1111.
- done pulses GAP_LEN cycles after the second visit ends.
REQ-032 Press key 0xF with BOUNCE_LEN 8 while the row is held at 0111.
- Required: keypadCol alternates 0111/1111 for 8 cycles, then 0111 steady.
REQ-033 Offer a second command (key 0x2) while busy.
- Required: cmd_ready=0, the second command is not latched, and the first completes unchanged.
REQ-034 Drive keypadRow=0000 and 1111 during HOLD for key 0x7.
- Required: keypadCol=1111 and the hit count is unchanged.
REQ-035 Assert reset during HOLD of key 0xA.
- Required: keypadCol=1111 asynchronously, cmd_ready=1, no done.
- A new command on the first edge after release is accepted.
REQ-036 Press key 0x0 with hold 0.
- Required: behaves identically to hold 1.

Source files
------------

// File: rtl/keypad_pkg.sv
// Shared definitions for the keypad emulator: FSM encoding and the
// active-low row/column patterns of the 4x4 matrix.
package keypad_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_BOUNCE = 2'd1,
    ST_HOLD   = 2'd2,
    ST_GAP    = 2'd3
  } state_t;

  localparam logic [3:0] ROW0   = 4'b1110;
  localparam logic [3:0] ROW1   = 4'b1101;
  localparam logic [3:0] ROW2   = 4'b1011;
  localparam logic [3:0] ROW3   = 4'b0111;
  localparam logic [3:0] COL0   = 4'b1110;
  localparam logic [3:0] COL1   = 4'b1101;
  localparam logic [3:0] COL2   = 4'b1011;
  localparam logic [3:0] COL3   = 4'b0111;
  localparam logic [3:0] NO_KEY = 4'b1111;

  // A scanner row drive is only meaningful when exactly one row is pulled low.
  function automatic logic row_is_valid(input logic [3:0] row);
    return (row == ROW0) || (row == ROW1) || (row == ROW2) || (row == ROW3);
  endfunction

endpackage

// File: rtl/keypad_key_map.sv
// Combinational key-code to matrix (row, col) lookup, shared with the scanner side.
module keypad_key_map
  import keypad_pkg::*;
(
  input  logic [3:0] key,
  output logic [3:0] row,
  output logic [3:0] col
);

  // Decode the key code into its active-low row and column patterns
  always_comb begin
    row = NO_KEY;
    col = NO_KEY;
    case (key)
      4'h7: begin row = ROW0; col = COL0; end
      4'h4: begin row = ROW0; col = COL1; end
      4'h1: begin row = ROW0; col = COL2; end
      4'h0: begin row = ROW0; col = COL3; end
      4'h8: begin row = ROW1; col = COL0; end
      4'h5: begin row = ROW1; col = COL1; end
      4'h2: begin row = ROW1; col = COL2; end
      4'hA: begin row = ROW1; col = COL3; end
      4'h9: begin row = ROW2; col = COL0; end
      4'h6: begin row = ROW2; col = COL1; end
      4'h3: begin row = ROW2; col = COL2; end
      4'hB: begin row = ROW2; col = COL3; end
      4'hC: begin row = ROW3; col = COL0; end
      4'hD: begin row = ROW3; col = COL1; end
      4'hE: begin row = ROW3; col = COL2; end
      4'hF: begin row = ROW3; col = COL3; end
      default: begin row = NO_KEY; col = NO_KEY; end
    endcase
  end

endmodule

// File: rtl/keypad_emulator.sv
// Emulates a key press on a scanned 4x4 matrix keypad: contact bounce,
// a hold measured in counted row visits, and a release gap before the next command.
module keypad_emulator
  import keypad_pkg::*;
#(
  parameter int BOUNCE_LEN = 8,
  parameter int GAP_LEN    = 16
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [3:0]  cmd_key,
  input  logic [15:0] cmd_hold,
  input  logic [3:0]  keypadRow,
  output logic [3:0]  keypadCol,
  output logic        busy,
  output logic        done
);

  localparam logic [15:0] BOUNCE_LAST = (BOUNCE_LEN > 0) ? 16'(BOUNCE_LEN - 1) : 16'd0;
  localparam logic [15:0] GAP_LAST    = (GAP_LEN > 0) ? 16'(GAP_LEN - 1) : 16'd0;

  state_t      state_r;
  logic [3:0]  key_r;
  logic [15:0] hold_r;
  logic [3:0]  prev_row_r;
  logic [3:0]  col_r;
  logic [15:0] hit_cnt_r;
  logic [15:0] bounce_cnt_r;
  logic [15:0] gap_cnt_r;
  logic        done_r;

  logic [3:0]  tgt_row_s;
  logic [3:0]  tgt_col_s;
  logic [3:0]  col_next_s;
  logic [15:0] hold_eff_s;
  logic        on_target_s;
  logic        hit_s;
  logic        hold_met_s;

  keypad_key_map u_key_map (
    .key (key_r),
    .row (tgt_row_s),
    .col (tgt_col_s)
  );

  // Row match, visit-edge detection and next column value
  always_comb begin
    on_target_s = row_is_valid(keypadRow) && (keypadRow == tgt_row_s);
    hit_s       = on_target_s && (prev_row_r != tgt_row_s);
    hold_eff_s  = (hold_r == 16'd0) ? 16'd1 : hold_r;
    hold_met_s  = (hit_cnt_r >= hold_eff_s);
    col_next_s  = NO_KEY;
    case (state_r)
      ST_HOLD:   col_next_s = on_target_s ? tgt_col_s : NO_KEY;
      ST_BOUNCE: col_next_s = (on_target_s && !bounce_cnt_r[0]) ? tgt_col_s : NO_KEY;
      default:   col_next_s = NO_KEY;
    endcase
  end

  // Command FSM, counters and registered column return
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_r      <= ST_IDLE;
      key_r        <= 4'h0;
      hold_r       <= 16'd0;
      prev_row_r   <= NO_KEY;
      col_r        <= NO_KEY;
      hit_cnt_r    <= 16'd0;
      bounce_cnt_r <= 16'd0;
      gap_cnt_r    <= 16'd0;
      done_r       <= 1'b0;
    end else begin
      prev_row_r <= keypadRow;
      col_r      <= col_next_s;
      done_r     <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (cmd_valid) begin
            key_r        <= cmd_key;
            hold_r       <= cmd_hold;
            hit_cnt_r    <= 16'd0;
            bounce_cnt_r <= 16'd0;
            gap_cnt_r    <= 16'd0;
            state_r      <= (BOUNCE_LEN > 0) ? ST_BOUNCE : ST_HOLD;
          end
        end
        ST_BOUNCE: begin
          if (bounce_cnt_r == BOUNCE_LAST) begin
            state_r <= ST_HOLD;
          end else begin
            bounce_cnt_r <= bounce_cnt_r + 16'd1;
          end
        end
        ST_HOLD: begin
          if (hit_s && (hit_cnt_r != 16'hFFFF)) begin
            hit_cnt_r <= hit_cnt_r + 16'd1;
          end
          // Leave only once the scanner has moved off the row, so a visit is never cut short
          if (hold_met_s && !on_target_s) begin
            if (GAP_LEN > 0) begin
              state_r <= ST_GAP;
            end else begin
              state_r <= ST_IDLE;
              done_r  <= 1'b1;
            end
          end
        end
        ST_GAP: begin
          if (gap_cnt_r == GAP_LAST) begin
            state_r <= ST_IDLE;
            done_r  <= 1'b1;
          end else begin
            gap_cnt_r <= gap_cnt_r + 16'd1;
          end
        end
        default: state_r <= ST_IDLE;
      endcase
    end
  end

  assign cmd_ready = (state_r == ST_IDLE);
  assign busy      = (state_r != ST_IDLE);
  assign keypadCol = col_r;
  assign done      = done_r;

endmodule

// File: tb/tb_keypad_emulator.sv
// Scoreboard bench for keypad_emulator: two instances (no bounce / 8-cycle bounce)
// driven on the falling edge, column and done checked on the next falling edge.
module tb_keypad_emulator;

  localparam int GAP = 16;

  typedef struct packed {
    logic [3:0] col;
    logic       done;
  } exp_t;

  logic        clock = 1'b0;
  logic        reset;
  logic        cmd_valid0, cmd_ready0, busy0, done0;
  logic [3:0]  cmd_key0, row0, col0;
  logic [15:0] cmd_hold0;
  logic        cmd_valid8, cmd_ready8, busy8, done8;
  logic [3:0]  cmd_key8, row8, col8;
  logic [15:0] cmd_hold8;

  int   checks = 0;
  int   errors = 0;
  exp_t sb_q[$];

  always #5 clock = ~clock;

  keypad_emulator #(.BOUNCE_LEN(0), .GAP_LEN(GAP)) dut0 (
    .clock(clock), .reset(reset), .cmd_valid(cmd_valid0), .cmd_ready(cmd_ready0),
    .cmd_key(cmd_key0), .cmd_hold(cmd_hold0), .keypadRow(row0), .keypadCol(col0),
    .busy(busy0), .done(done0)
  );

  keypad_emulator #(.BOUNCE_LEN(8), .GAP_LEN(GAP)) dut8 (
    .clock(clock), .reset(reset), .cmd_valid(cmd_valid8), .cmd_ready(cmd_ready8),
    .cmd_key(cmd_key8), .cmd_hold(cmd_hold8), .keypadRow(row8), .keypadCol(col8),
    .busy(busy8), .done(done8)
  );

  task automatic test_reset();
    reset = 1'b1;
    cmd_valid0 = 1'b0; cmd_key0 = 4'h0; cmd_hold0 = 16'd0; row0 = 4'b1111;
    cmd_valid8 = 1'b0; cmd_key8 = 4'h0; cmd_hold8 = 16'd0; row8 = 4'b1111;
    repeat (3) @(negedge clock);
    checks++;
    if (col0 !== 4'b1111 || cmd_ready0 !== 1'b1 || busy0 !== 1'b0 || done0 !== 1'b0) begin
      errors++;
      $display("FAIL reset_dut0: col=%b ready=%b busy=%b done=%b, want 1111 1 0 0", col0, cmd_ready0, busy0, done0);
    end
    checks++;
    if (col8 !== 4'b1111 || cmd_ready8 !== 1'b1 || busy8 !== 1'b0 || done8 !== 1'b0) begin
      errors++;
      $display("FAIL reset_dut8: col=%b ready=%b busy=%b done=%b, want 1111 1 0 0", col8, cmd_ready8, busy8, done8);
    end
    reset = 1'b0;
  endtask

  // Key 5, hold 2, scanner dwelling 100 cycles per row
  task automatic test_press_sequence();
    logic [3:0] rows [4];
    logic [3:0] r;
    logic [3:0] last_r = 4'b1111;
    int   visit = 0;
    int   exit_j = -1;
    exp_t e;
    rows[0] = 4'b1110; rows[1] = 4'b1101; rows[2] = 4'b1011; rows[3] = 4'b0111;
    sb_q.delete();
    row0 = 4'b1111;
    @(negedge clock);
    checks++;
    if (cmd_ready0 !== 1'b1) begin
      errors++;
      $display("FAIL press_ready: cmd_ready=%b, want 1", cmd_ready0);
    end
    for (int j = 0; j <= 900; j++) begin
      if (sb_q.size() != 0) begin
        e = sb_q.pop_front();
        checks++;
        if (col0 !== e.col || done0 !== e.done) begin
          errors++;
          $display("FAIL press_seq[%0d]: col=%b done=%b, want col=%b done=%b", j, col0, done0, e.col, e.done);
        end
      end
      if (j < 900) begin
        r = (j == 0) ? 4'b1111 : rows[((j - 1) / 100) % 4];
        if (r == 4'b1101 && last_r != 4'b1101) visit++;
        if (visit == 2 && r != 4'b1101 && exit_j < 0) exit_j = j;
        e.col  = (r == 4'b1101 && visit <= 2) ? 4'b1101 : 4'b1111;
        e.done = (exit_j >= 0 && j == exit_j + GAP);
        cmd_valid0 = (j == 0); cmd_key0 = 4'h5; cmd_hold0 = 16'd2;
        row0 = r;
        last_r = r;
        sb_q.push_back(e);
        @(negedge clock);
      end
    end
  endtask

  // Key F with 8-cycle bounce while the row already sits on 0111
  task automatic test_bounce();
    logic [3:0] r;
    exp_t e;
    sb_q.delete();
    row8 = 4'b0111;
    @(negedge clock);
    checks++;
    if (cmd_ready8 !== 1'b1) begin
      errors++;
      $display("FAIL bounce_ready: cmd_ready=%b, want 1", cmd_ready8);
    end
    for (int j = 0; j <= 50; j++) begin
      if (sb_q.size() != 0) begin
        e = sb_q.pop_front();
        checks++;
        if (col8 !== e.col || done8 !== e.done) begin
          errors++;
          $display("FAIL bounce[%0d]: col=%b done=%b, want col=%b done=%b", j, col8, done8, e.col, e.done);
        end
      end
      if (j < 50) begin
        r = ((j >= 21 && j <= 23) || j >= 27) ? 4'b1110 : 4'b0111;
        if (j == 0) e.col = 4'b1111;
        else if (j <= 8) e.col = ((j % 2) == 1) ? 4'b0111 : 4'b1111;
        else e.col = (r == 4'b0111) ? 4'b0111 : 4'b1111;
        e.done = (j == 27 + GAP);
        cmd_valid8 = (j == 0); cmd_key8 = 4'hF; cmd_hold8 = 16'd1;
        row8 = r;
        sb_q.push_back(e);
        @(negedge clock);
      end
    end
  endtask

  // Key 3 hold 1 accepted, then key 2 hold 5 offered while busy
  task automatic test_busy_reject();
    logic [3:0] r;
    exp_t e;
    sb_q.delete();
    row0 = 4'b1111;
    @(negedge clock);
    for (int j = 0; j <= 40; j++) begin
      if (sb_q.size() != 0) begin
        e = sb_q.pop_front();
        checks++;
        if (col0 !== e.col || done0 !== e.done) begin
          errors++;
          $display("FAIL busy_reject[%0d]: col=%b done=%b, want col=%b done=%b", j, col0, done0, e.col, e.done);
        end
      end
      if (j >= 1 && j <= 5) begin
        checks++;
        if (cmd_ready0 !== 1'b0 || busy0 !== 1'b1) begin
          errors++;
          $display("FAIL busy_ready[%0d]: ready=%b busy=%b, want 0 1", j, cmd_ready0, busy0);
        end
      end
      if (j < 40) begin
        if (j == 0) r = 4'b1111;
        else if (j <= 5) r = 4'b1101;
        else if (j <= 10) r = 4'b1011;
        else r = 4'b1110;
        e.col  = (r == 4'b1011) ? 4'b1011 : 4'b1111;
        e.done = (j == 11 + GAP);
        cmd_valid0 = (j <= 5);
        cmd_key0   = (j == 0) ? 4'h3 : 4'h2;
        cmd_hold0  = (j == 0) ? 16'd1 : 16'd5;
        row0 = r;
        sb_q.push_back(e);
        @(negedge clock);
      end
    end
    cmd_valid0 = 1'b0;
  endtask

  // Key 7 hold 2 with non-one-hot rows between the two visits
  task automatic test_invalid_rows();
    logic [3:0] r;
    exp_t e;
    sb_q.delete();
    row0 = 4'b1111;
    @(negedge clock);
    for (int j = 0; j <= 45; j++) begin
      if (sb_q.size() != 0) begin
        e = sb_q.pop_front();
        checks++;
        if (col0 !== e.col || done0 !== e.done) begin
          errors++;
          $display("FAIL invalid_rows[%0d]: col=%b done=%b, want col=%b done=%b", j, col0, done0, e.col, e.done);
        end
      end
      if (j < 45) begin
        if (j == 0) r = 4'b1111;
        else if (j <= 3) r = 4'b1110;
        else if (j <= 6) r = 4'b0000;
        else if (j <= 9) r = 4'b1111;
        else if (j <= 11) r = 4'b1100;
        else if (j <= 14) r = 4'b1101;
        else if (j <= 17) r = 4'b1110;
        else r = 4'b1101;
        e.col  = (j != 0 && r == 4'b1110) ? 4'b1110 : 4'b1111;
        e.done = (j == 18 + GAP);
        cmd_valid0 = (j == 0); cmd_key0 = 4'h7; cmd_hold0 = 16'd2;
        row0 = r;
        sb_q.push_back(e);
        @(negedge clock);
      end
    end
  endtask

  // Key A hold 3 interrupted by reset, then a fresh command right after release
  task automatic test_reset_mid_command();
    exp_t e;
    int   done_seen = 0;
    sb_q.delete();
    row0 = 4'b1111;
    @(negedge clock);
    for (int j = 0; j <= 5; j++) begin
      if (sb_q.size() != 0) begin
        e = sb_q.pop_front();
        checks++;
        if (col0 !== e.col || done0 !== e.done) begin
          errors++;
          $display("FAIL reset_mid_hold[%0d]: col=%b done=%b, want col=%b done=%b", j, col0, done0, e.col, e.done);
        end
      end
      if (j < 5) begin
        cmd_valid0 = (j == 0); cmd_key0 = 4'hA; cmd_hold0 = 16'd3;
        row0   = (j == 0) ? 4'b1111 : 4'b1101;
        e.col  = (j == 0) ? 4'b1111 : 4'b0111;
        e.done = 1'b0;
        sb_q.push_back(e);
        @(negedge clock);
      end
    end
    #2 reset = 1'b1;
    #1;
    checks++;
    if (col0 !== 4'b1111 || cmd_ready0 !== 1'b1 || busy0 !== 1'b0 || done0 !== 1'b0) begin
      errors++;
      $display("FAIL reset_async: col=%b ready=%b busy=%b done=%b, want 1111 1 0 0", col0, cmd_ready0, busy0, done0);
    end
    for (int k = 0; k < 3; k++) begin
      @(negedge clock);
      checks++;
      if (done0 !== 1'b0 || col0 !== 4'b1111) begin
        errors++;
        $display("FAIL reset_held[%0d]: col=%b done=%b, want 1111 0", k, col0, done0);
      end
    end
    reset = 1'b0;
    cmd_valid0 = 1'b1; cmd_key0 = 4'h0; cmd_hold0 = 16'd1; row0 = 4'b1111;
    @(negedge clock);
    cmd_valid0 = 1'b0;
    checks++;
    if (busy0 !== 1'b1 || cmd_ready0 !== 1'b0) begin
      errors++;
      $display("FAIL reset_first_cmd: busy=%b ready=%b, want 1 0", busy0, cmd_ready0);
    end
    for (int k = 0; k < 60 && done_seen == 0; k++) begin
      row0 = (k < 3) ? 4'b1110 : 4'b1111;
      @(negedge clock);
      if (done0 === 1'b1) done_seen++;
    end
    checks++;
    if (done_seen != 1) begin
      errors++;
      $display("FAIL reset_resume_done: done pulses=%0d within 60 cycles, want 1", done_seen);
    end
  endtask

  // Key 0 run with hold 1 and then hold 0 against the same expectations
  task automatic test_hold_zero();
    logic [3:0]  r;
    logic [15:0] h;
    exp_t e;
    for (int pass = 0; pass < 2; pass++) begin
      h = (pass == 0) ? 16'd1 : 16'd0;
      sb_q.delete();
      row0 = 4'b1111;
      @(negedge clock);
      checks++;
      if (cmd_ready0 !== 1'b1) begin
        errors++;
        $display("FAIL hold_zero_ready(hold=%0d): cmd_ready=%b, want 1", h, cmd_ready0);
      end
      for (int j = 0; j <= 30; j++) begin
        if (sb_q.size() != 0) begin
          e = sb_q.pop_front();
          checks++;
          if (col0 !== e.col || done0 !== e.done) begin
            errors++;
            $display("FAIL hold_zero(hold=%0d)[%0d]: col=%b done=%b, want col=%b done=%b", h, j, col0, done0, e.col, e.done);
          end
        end
        if (j < 30) begin
          if (j == 0) r = 4'b1111;
          else if (j <= 3) r = 4'b1101;
          else if (j <= 7) r = 4'b1110;
          else r = 4'b1101;
          e.col  = (r == 4'b1110) ? 4'b0111 : 4'b1111;
          e.done = (j == 8 + GAP);
          cmd_valid0 = (j == 0); cmd_key0 = 4'h0; cmd_hold0 = h;
          row0 = r;
          sb_q.push_back(e);
          @(negedge clock);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_press_sequence();
    test_bounce();
    test_busy_reject();
    test_invalid_rows();
    test_reset_mid_command();
    test_hold_zero();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
